// File: rtl/reg_f_pkg.sv
`default_nettype none
// ============================================================================
// reg_f_pkg : shared types and frame addressing helpers for reg_f_ctx
// Revision  : 1.0
// ============================================================================
package reg_f_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_POP  = 2'd2
  } reg_f_state_t;

  // Number of writable registers saved in one context frame
  function automatic int frame_n(input int size, input int ro_regs);
    return size - ro_regs;
  endfunction

  // Flat stack entry holding register slot idx of frame number frame
  function automatic int entry_addr(input int frame, input int n, input int idx);
    return frame * n + idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_f_stack_mem.sv
`default_nettype none
// ============================================================================
// reg_f_stack_mem : context stack storage, one write port, one async read port
// Revision        : 1.0
// ============================================================================
module reg_f_stack_mem
  import reg_f_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 36,
  parameter int AW      = 6
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/reg_f_ctx.sv
`default_nettype none
// ============================================================================
// reg_f_ctx : register file with constant low registers and a context stack
// Revision  : 1.0
// ============================================================================
module reg_f_ctx
  import reg_f_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SIZE        = 11,
  parameter int RO_REGS     = 2,
  parameter int ACC_ADDR    = 2,
  parameter int STACK_DEPTH = 4,
  parameter int BYPASS      = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [$clog2(SIZE)-1:0]          rf_addr_r1,
  input  logic [$clog2(SIZE)-1:0]          rf_addr_r2,
  output logic [WIDTH-1:0]                 rf_data_out1,
  output logic [WIDTH-1:0]                 rf_data_out2,
  input  logic [$clog2(SIZE)-1:0]          rf_addr_wr,
  input  logic                             rf_data_we,
  input  logic [WIDTH-1:0]                 rf_data_in,
  input  logic                             rf_stack_push,
  input  logic                             rf_stack_pop,
  output logic                             rf_stack_busy,
  output logic [$clog2(STACK_DEPTH+1)-1:0] rf_stack_pointer,
  output logic                             rf_stack_ovf,
  output logic                             rf_stack_unf,
  output logic                             rf_acc_zero
);

  localparam int c_aw      = $clog2(SIZE);
  localparam int c_n       = frame_n(SIZE, RO_REGS);
  localparam int c_entries = STACK_DEPTH * c_n;
  localparam int c_eaw     = (c_entries > 1) ? $clog2(c_entries) : 1;
  localparam int c_iw      = (c_n > 1) ? $clog2(c_n) : 1;
  localparam int c_pw      = $clog2(STACK_DEPTH + 1);
  localparam int c_acc_idx = ACC_ADDR - RO_REGS;

  localparam logic [c_iw-1:0] c_idx_one = c_iw'(1);
  localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);

  reg_f_state_t     r_state, w_state_nxt;
  logic [c_iw-1:0]  r_idx, w_idx_nxt;
  logic [c_pw-1:0]  r_ptr, w_ptr_nxt;
  logic             r_ovf, r_unf, w_ovf_nxt, w_unf_nxt;
  logic [WIDTH-1:0] r_regs [c_n];
  logic             w_wr_acc;
  logic             w_mem_we;
  logic             w_last;
  logic [c_iw-1:0]  w_wr_idx;
  logic [c_eaw-1:0] w_entry;
  logic [WIDTH-1:0] w_mem_rdata;

  assign w_wr_acc = rf_data_we && (r_state == ST_IDLE) &&
                    (int'(rf_addr_wr) >= RO_REGS) && (int'(rf_addr_wr) < SIZE);
  assign w_wr_idx = c_iw'(int'(rf_addr_wr) - RO_REGS);
  assign w_last   = (int'(r_idx) == c_n - 1);

  // A push fills the frame above the top; a pop drains the top frame
  assign w_entry = c_eaw'(entry_addr((r_state == ST_POP) ? int'(r_ptr) - 1 : int'(r_ptr),
                                     c_n, int'(r_idx)));

  reg_f_stack_mem #(
    .WIDTH   (WIDTH),
    .ENTRIES (c_entries),
    .AW      (c_eaw)
  ) u_stack_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_entry),
    .i_wdata (r_regs[r_idx]),
    .i_raddr (w_entry),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_ovf_nxt   = 1'b0;
    w_unf_nxt   = 1'b0;
    w_mem_we    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_idx_nxt = '0;
        // Push has priority; a simultaneous pop is dropped
        if (rf_stack_push) begin
          if (int'(r_ptr) < STACK_DEPTH) w_state_nxt = ST_PUSH;
          else                           w_ovf_nxt   = 1'b1;
        end else if (rf_stack_pop) begin
          if (r_ptr != '0) w_state_nxt = ST_POP;
          else             w_unf_nxt   = 1'b1;
        end
      end
      ST_PUSH: begin
        w_mem_we = 1'b1;
        if (w_last) begin
          w_idx_nxt   = '0;
          w_ptr_nxt   = r_ptr + c_ptr_one;
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt = r_idx + c_idx_one;
        end
      end
      ST_POP: begin
        if (w_last) begin
          w_idx_nxt   = '0;
          w_ptr_nxt   = r_ptr - c_ptr_one;
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt = r_idx + c_idx_one;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_n; i++) r_regs[i] <= '0;
    end else if (r_state == ST_POP) begin
      r_regs[r_idx] <= w_mem_rdata;
    end else if (w_wr_acc) begin
      r_regs[w_wr_idx] <= rf_data_in;
    end
  end

  function automatic logic [WIDTH-1:0] f_read_port(input logic [c_aw-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if (int'(a) >= SIZE)                                v = '0;
    else if (int'(a) < RO_REGS)                         v = WIDTH'(a);
    else if ((BYPASS != 0) && w_wr_acc && (a == rf_addr_wr)) v = rf_data_in;
    else                                                v = r_regs[c_iw'(int'(a) - RO_REGS)];
    return v;
  endfunction

  always_comb begin
    rf_data_out1 = f_read_port(rf_addr_r1);
    rf_data_out2 = f_read_port(rf_addr_r2);
  end

  assign rf_acc_zero      = (r_regs[c_acc_idx] == '0);
  assign rf_stack_busy    = (r_state != ST_IDLE);
  assign rf_stack_pointer = r_ptr;
  assign rf_stack_ovf     = r_ovf;
  assign rf_stack_unf     = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_reg_f_ctx.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// tb_reg_f_ctx : randomized bench for reg_f_ctx against a frame-level model
// Revision     : 1.0
// ============================================================================
module tb_reg_f_ctx;

  localparam int WIDTH = 8, SIZE = 11, RO_REGS = 2, ACC_ADDR = 2, STACK_DEPTH = 4;
  localparam int N = SIZE - RO_REGS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rf_addr_r1, rf_addr_r2, rf_addr_wr;
  logic       rf_data_we, rf_stack_push, rf_stack_pop;
  logic [7:0] rf_data_in;
  logic [7:0] out1, out2, nb_out1, nb_out2;
  logic       busy, ovf, unf, accz, nb_busy, nb_ovf, nb_unf, nb_accz;
  logic [2:0] ptr, nb_ptr;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_regs [SIZE];
  logic [7:0] m_stack [STACK_DEPTH][N];
  int         m_ptr;
  logic [7:0] snap [16];
  logic [7:0] snap_nb [16];

  always #5 clk = ~clk;

  reg_f_ctx #(.WIDTH(WIDTH), .SIZE(SIZE), .RO_REGS(RO_REGS), .ACC_ADDR(ACC_ADDR),
              .STACK_DEPTH(STACK_DEPTH), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2),
    .rf_data_out1(out1), .rf_data_out2(out2), .rf_addr_wr(rf_addr_wr),
    .rf_data_we(rf_data_we), .rf_data_in(rf_data_in), .rf_stack_push(rf_stack_push),
    .rf_stack_pop(rf_stack_pop), .rf_stack_busy(busy), .rf_stack_pointer(ptr),
    .rf_stack_ovf(ovf), .rf_stack_unf(unf), .rf_acc_zero(accz));

  reg_f_ctx #(.WIDTH(WIDTH), .SIZE(SIZE), .RO_REGS(RO_REGS), .ACC_ADDR(ACC_ADDR),
              .STACK_DEPTH(STACK_DEPTH), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2),
    .rf_data_out1(nb_out1), .rf_data_out2(nb_out2), .rf_addr_wr(rf_addr_wr),
    .rf_data_we(rf_data_we), .rf_data_in(rf_data_in), .rf_stack_push(rf_stack_push),
    .rf_stack_pop(rf_stack_pop), .rf_stack_busy(nb_busy), .rf_stack_pointer(nb_ptr),
    .rf_stack_ovf(nb_ovf), .rf_stack_unf(nb_unf), .rf_acc_zero(nb_accz));

  // ---------------- reference model ----------------
  function automatic logic [7:0] exp_read(input int a);
    if (a >= SIZE)    return 8'h00;
    if (a < RO_REGS)  return 8'(a);
    return m_regs[a];
  endfunction

  function automatic bit legal_wr(input int a);
    return (a >= RO_REGS) && (a < SIZE);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SIZE; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
  endtask

  task automatic model_push();
    for (int i = 0; i < N; i++) m_stack[m_ptr][i] = m_regs[RO_REGS + i];
    m_ptr++;
  endtask

  task automatic model_pop();
    m_ptr--;
    for (int i = 0; i < N; i++) m_regs[RO_REGS + i] = m_stack[m_ptr][i];
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rf_data_we = 1'b0; rf_stack_push = 1'b0; rf_stack_pop = 1'b0;
    rf_addr_wr = 4'd0; rf_data_in = 8'h00;
  endtask

  task automatic write_reg(input int a, input logic [7:0] d);
    rf_data_we = 1'b1; rf_addr_wr = 4'(a); rf_data_in = d;
    tick();
    rf_data_we = 1'b0;
    if (legal_wr(a)) m_regs[a] = d;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      rf_addr_r1 = 4'(a); rf_addr_r2 = 4'(a);
      #0.2;
      snap[a] = out1;
      snap_nb[a] = nb_out2;
    end
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    if (busy !== 1'b0) errors++;
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", ptr); end
    checks++; if (accz !== 1'b1) begin errors++; $display("FAIL reset_acc_zero: got %b expected 1", accz); end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ovf=%b unf=%b expected 0 0", ovf, unf);
    end
    read_all();
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (snap[a] !== exp_read(a) || snap_nb[a] !== exp_read(a)) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h/%h expected %h", a, snap[a], snap_nb[a], exp_read(a));
      end
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ro_write();
    write_reg(3, 8'hB5);
    write_reg(0, 8'h8A);
    write_reg(1, 8'h1F);
    read_all();
    checks++; if (snap[3] !== 8'hB5) begin errors++; $display("FAIL ro_reg3: got %h expected b5", snap[3]); end
    checks++; if (snap[0] !== 8'h00) begin errors++; $display("FAIL ro_reg0: got %h expected 00", snap[0]); end
    checks++; if (snap[1] !== 8'h01) begin errors++; $display("FAIL ro_reg1: got %h expected 01", snap[1]); end
    for (int a = 11; a < 16; a++) begin
      checks++;
      if (snap[a] !== 8'h00) begin errors++; $display("FAIL oob_read[%0d]: got %h expected 00", a, snap[a]); end
    end
  endtask

  task automatic test_bypass();
    rf_addr_r1 = 4'd5; rf_addr_r2 = 4'd4;
    rf_data_we = 1'b1; rf_addr_wr = 4'd4; rf_data_in = 8'hAC;
    #1;
    checks++; if (out2 !== 8'hAC) begin errors++; $display("FAIL bypass_on: got %h expected ac", out2); end
    checks++; if (nb_out2 !== 8'h00) begin errors++; $display("FAIL bypass_off: got %h expected 00", nb_out2); end
    checks++; if (out1 !== m_regs[5]) begin errors++; $display("FAIL bypass_other: got %h expected %h", out1, m_regs[5]); end
    tick();
    m_regs[4] = 8'hAC;
    rf_data_we = 1'b0;
    #1;
    checks++; if (nb_out2 !== 8'hAC) begin errors++; $display("FAIL bypass_commit: got %h expected ac", nb_out2); end
    // Bypass must not apply to constant or out-of-range addresses
    rf_data_we = 1'b1; rf_addr_wr = 4'd1; rf_data_in = 8'h55; rf_addr_r1 = 4'd1;
    rf_addr_r2 = 4'd13;
    #1;
    checks++; if (out1 !== 8'h01) begin errors++; $display("FAIL bypass_ro: got %h expected 01", out1); end
    rf_addr_wr = 4'd13;
    #1;
    checks++; if (out2 !== 8'h00) begin errors++; $display("FAIL bypass_oob: got %h expected 00", out2); end
    tick();
    rf_data_we = 1'b0;
  endtask

  task automatic test_random_rw();
    logic [7:0] e1, e2, n1, n2;
    bit         acc;
    for (int it = 0; it < 60; it++) begin
      rf_data_we = 1'($urandom_range(0, 1));
      rf_addr_wr = 4'($urandom_range(0, 15));
      rf_data_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rf_addr_r1 = 4'($urandom_range(0, 15));
      rf_addr_r2 = ($urandom_range(0, 2) == 0) ? rf_addr_wr : 4'($urandom_range(0, 15));
      #1;
      acc = rf_data_we && legal_wr(int'(rf_addr_wr));
      n1 = exp_read(int'(rf_addr_r1));
      n2 = exp_read(int'(rf_addr_r2));
      e1 = (acc && rf_addr_r1 == rf_addr_wr) ? rf_data_in : n1;
      e2 = (acc && rf_addr_r2 == rf_addr_wr) ? rf_data_in : n2;
      checks++;
      if (out1 !== e1 || out2 !== e2) begin
        errors++;
        $display("FAIL rand_read_bypass it=%0d: got %h %h expected %h %h", it, out1, out2, e1, e2);
      end
      checks++;
      if (nb_out1 !== n1 || nb_out2 !== n2) begin
        errors++;
        $display("FAIL rand_read_stored it=%0d: got %h %h expected %h %h", it, nb_out1, nb_out2, n1, n2);
      end
      checks++;
      if (accz !== (m_regs[ACC_ADDR] == 8'h00)) begin
        errors++;
        $display("FAIL rand_acc_zero it=%0d: got %b expected %b", it, accz, m_regs[ACC_ADDR] == 8'h00);
      end
      tick();
      if (acc) m_regs[rf_addr_wr] = rf_data_in;
    end
    idle_in();
  endtask

  task automatic test_push_pop();
    int cnt;
    write_reg(3, 8'hDC);
    rf_stack_push = 1'b1;
    tick();
    rf_stack_push = 1'b0;
    model_push();
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (cnt == 2) begin
        rf_data_we = 1'b1; rf_addr_wr = 4'd5; rf_data_in = 8'h77; rf_stack_push = 1'b1;
      end else begin
        rf_data_we = 1'b0; rf_stack_push = 1'b0;
      end
      cnt++;
      tick();
    end
    idle_in();
    checks++; if (cnt !== 9) begin errors++; $display("FAIL push_busy_cycles: got %0d expected 9", cnt); end
    checks++; if (ptr !== 3'd1) begin errors++; $display("FAIL push_ptr: got %0d expected 1", ptr); end
    write_reg(3, 8'h11);
    write_reg(2, 8'h00);
    write_reg(10, ~m_regs[10]);
    checks++; if (accz !== 1'b1) begin errors++; $display("FAIL pp_acc_zero: got %b expected 1", accz); end
    rf_stack_pop = 1'b1;
    tick();
    rf_stack_pop = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      // Partially restored: slots below idx restored, the rest still current
      if (cnt == 4) begin
        rf_addr_r1 = 4'd3; rf_addr_r2 = 4'd10;
        #1;
        checks++;
        if (out1 !== 8'hDC || out2 !== m_regs[10]) begin
          errors++;
          $display("FAIL pop_partial: got %h %h expected dc %h", out1, out2, m_regs[10]);
        end
      end
      if (cnt == 2) begin
        rf_data_we = 1'b1; rf_addr_wr = 4'd6; rf_data_in = 8'h99;
      end else begin
        rf_data_we = 1'b0;
      end
      cnt++;
      tick();
    end
    idle_in();
    model_pop();
    checks++; if (cnt !== 9) begin errors++; $display("FAIL pop_busy_cycles: got %0d expected 9", cnt); end
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL pop_ptr: got %0d expected 0", ptr); end
    read_all();
    checks++; if (snap[3] !== 8'hDC) begin errors++; $display("FAIL pop_reg3: got %h expected dc", snap[3]); end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (snap[a] !== exp_read(a)) begin
        errors++; $display("FAIL pop_restore[%0d]: got %h expected %h", a, snap[a], exp_read(a));
      end
    end
  endtask

  task automatic test_ovf_unf();
    int cnt;
    for (int f = 0; f < STACK_DEPTH; f++) begin
      for (int r = RO_REGS; r < SIZE; r++) write_reg(r, 8'($urandom));
      rf_stack_push = 1'b1;
      tick();
      rf_stack_push = 1'b0;
      wait_idle(cnt);
      model_push();
      checks++;
      if (cnt !== N || ptr !== 3'(m_ptr)) begin
        errors++; $display("FAIL fill_push f=%0d: got cycles=%0d ptr=%0d expected %0d %0d", f, cnt, ptr, N, m_ptr);
      end
    end
    rf_stack_push = 1'b1; rf_stack_pop = 1'b1;
    tick();
    rf_stack_push = 1'b0; rf_stack_pop = 1'b0;
    checks++;
    if (ovf !== 1'b1 || unf !== 1'b0 || busy !== 1'b0 || ptr !== 3'd4) begin
      errors++; $display("FAIL ovf_pulse: got ovf=%b unf=%b busy=%b ptr=%0d expected 1 0 0 4", ovf, unf, busy, ptr);
    end
    tick();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b expected 0", ovf); end
    for (int f = 0; f < STACK_DEPTH; f++) begin
      rf_stack_pop = 1'b1;
      tick();
      rf_stack_pop = 1'b0;
      wait_idle(cnt);
      model_pop();
      read_all();
      for (int a = 0; a < SIZE; a++) begin
        checks++;
        if (snap[a] !== exp_read(a)) begin
          errors++; $display("FAIL drain_pop f=%0d reg%0d: got %h expected %h", f, a, snap[a], exp_read(a));
        end
      end
    end
    rf_stack_pop = 1'b1;
    tick();
    rf_stack_pop = 1'b0;
    checks++;
    if (unf !== 1'b1 || busy !== 1'b0 || ptr !== 3'd0) begin
      errors++; $display("FAIL unf_pulse: got unf=%b busy=%b ptr=%0d expected 1 0 0", unf, busy, ptr);
    end
    tick();
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL unf_one_cycle: got %b expected 0", unf); end
    read_all();
    for (int a = 0; a < SIZE; a++) begin
      checks++;
      if (snap[a] !== exp_read(a)) begin
        errors++; $display("FAIL unf_regs reg%0d: got %h expected %h", a, snap[a], exp_read(a));
      end
    end
    rf_stack_push = 1'b1; rf_stack_pop = 1'b1;
    tick();
    rf_stack_push = 1'b0; rf_stack_pop = 1'b0;
    checks++;
    if (busy !== 1'b1 || unf !== 1'b0) begin
      errors++; $display("FAIL push_wins: got busy=%b unf=%b expected 1 0", busy, unf);
    end
    wait_idle(cnt);
    model_push();
    checks++; if (ptr !== 3'd1) begin errors++; $display("FAIL push_wins_ptr: got %0d expected 1", ptr); end
    rf_stack_pop = 1'b1;
    tick();
    rf_stack_pop = 1'b0;
    wait_idle(cnt);
    model_pop();
  endtask

  task automatic test_acc();
    int cnt;
    rf_data_we = 1'b1; rf_addr_wr = 4'd2; rf_data_in = 8'h1F; rf_stack_push = 1'b1;
    tick();
    idle_in();
    m_regs[2] = 8'h1F;
    model_push();
    wait_idle(cnt);
    checks++;
    if (accz !== 1'b0 || ptr !== 3'd1 || cnt !== N) begin
      errors++; $display("FAIL acc_push: got accz=%b ptr=%0d cycles=%0d expected 0 1 %0d", accz, ptr, cnt, N);
    end
    write_reg(2, 8'h00);
    checks++; if (accz !== 1'b1) begin errors++; $display("FAIL acc_clear: got %b expected 1", accz); end
    rf_stack_pop = 1'b1;
    tick();
    rf_stack_pop = 1'b0;
    wait_idle(cnt);
    model_pop();
    rf_addr_r1 = 4'd2;
    #1;
    checks++;
    if (accz !== 1'b0 || out1 !== 8'h1F) begin
      errors++; $display("FAIL acc_restore: got accz=%b reg2=%h expected 0 1f", accz, out1);
    end
  endtask

  task automatic test_reset_mid();
    write_reg(2, 8'h3C);
    write_reg(7, 8'hA5);
    rf_stack_push = 1'b1;
    tick();
    rf_stack_push = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (busy !== 1'b0 || ptr !== 3'd0 || accz !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got busy=%b ptr=%0d accz=%b expected 0 0 1", busy, ptr, accz);
    end
    read_all();
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (snap[a] !== exp_read(a)) begin
        errors++; $display("FAIL mid_reset_reg%0d: got %h expected %h", a, snap[a], exp_read(a));
      end
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  initial begin
    idle_in();
    rf_addr_r1 = 4'd0; rf_addr_r2 = 4'd0;
    test_reset();
    test_ro_write();
    test_bypass();
    test_random_rw();
    test_push_pop();
    test_ovf_unf();
    test_acc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_f_ctx.md
REG_F_CTX -- requirements
Module: reg_f_ctx

Interface
REQ-001 SHALL have parameters: WIDTH 8, data bits; SIZE 11, register count; RO_REGS 2, low read-only registers; ACC_ADDR 2, accumulator index; STACK_DEPTH 4, context frames; BYPASS 1, write-to-read forwarding enable.
REQ-002 SHALL have ports: clk in 1, single clock; rst_n in 1, reset, asynchronous, active-low.
REQ-003 rf_addr_r1, rf_addr_r2  in  $clog2(SIZE)  read addresses; rf_data_out1, rf_data_out2  out  WIDTH  combinational read data.
REQ-004 rf_addr_wr  in  $clog2(SIZE)  write address; rf_data_we  in  1  write enable; rf_data_in  in  WIDTH  write data.
REQ-005 rf_stack_push, rf_stack_pop  in  1  context save/restore requests; rf_stack_busy  out  1  transfer in progress.
REQ-006 rf_stack_pointer  out  $clog2(STACK_DEPTH+1)  frames held; rf_stack_ovf, rf_stack_unf  out  1  one-cycle error pulses; rf_acc_zero  out  1  accumulator equals zero.

Function
REQ-007 Register i < RO_REGS SHALL read constant i (reg0=0, reg1=1) and ignore writes.
REQ-008 Writes SHALL commit at posedge clk when rf_data_we=1, rf_addr_wr in RO_REGS..SIZE-1, state IDLE; otherwise ignored.
REQ-009 Read address >= SIZE SHALL return 0.
REQ-010 With BYPASS=1, read address equal to an accepted write address SHALL return rf_data_in in the same cycle; BYPASS=0 returns stored value.
REQ-011 rf_acc_zero SHALL equal (reg[ACC_ADDR]==0), combinational from stored value.
REQ-012 Frame size N = SIZE-RO_REGS; frame f SHALL hold registers RO_REGS..SIZE-1 at stack entries f*N..f*N+N-1.
REQ-013 FSM states IDLE, PUSH, POP; index counter 0..N-1 active in PUSH/POP.
REQ-014 IDLE, push=1, pointer<STACK_DEPTH: go PUSH; each cycle copy reg[RO_REGS+idx] to entry pointer*N+idx; after idx=N-1 copy, pointer+1, return IDLE.
REQ-015 IDLE, pop=1, pointer>0: go POP; each cycle copy entry (pointer-1)*N+idx to reg[RO_REGS+idx]; after idx=N-1, pointer-1, return IDLE.
REQ-016 Push at pointer=STACK_DEPTH SHALL pulse rf_stack_ovf one cycle, no state change; pop at pointer=0 SHALL pulse rf_stack_unf likewise.
REQ-017 push and pop together in IDLE: push wins, pop dropped silently.
REQ-018 Write accepted in the same cycle a push is accepted SHALL be captured in the saved frame.
REQ-019 rf_stack_busy SHALL be 1 exactly while state is PUSH or POP: N cycles per transfer; requests and writes during busy ignored.
REQ-020 Reads during POP SHALL return current register contents (partially restored frame visible).

Reset
REQ-021 rst_n=0 SHALL asynchronously force state IDLE, idx 0, pointer 0, flags 0, writable registers 0 (rf_acc_zero=1, rf_stack_busy=0).
REQ-022 Reset mid PUSH/POP SHALL abort the transfer; stack storage not reset, contents don't-care.

Structure
REQ-023 Package reg_f_pkg SHALL hold FSM state enum and frame-size/entry-address helper constants.
REQ-024 Stack storage SHALL be sub-module reg_f_stack_mem: STACK_DEPTH*N x WIDTH, one write port, one async read port, no reset.

Verification
REQ-025 Write 0xB5 to reg3, then 0x8A to reg0 and 0x1F to reg1 -> reg3 reads 0xB5, reg0 reads 0x00, reg1 reads 0x01.
REQ-026 Write reg4=0xAC with r2=4 same cycle, BYPASS=1 -> out2=0xAC before edge; BYPASS=0 build -> old value 0x00.
REQ-027 reg3=0xDC, push, overwrite reg3=0x11, reg2=0x00, pop -> busy high 9 cycles each, reg3=0xDC restored, pointer 0->1->0.
REQ-028 Four pushes then fifth push -> pointer 4, ovf one-cycle pulse; pop at pointer 0 -> unf pulse, registers unchanged.
REQ-029 Write reg2=0x1F with push same cycle, clear reg2, pop -> reg2=0x1F, rf_acc_zero 0->1->0.
REQ-030 rst_n low at 4th PUSH cycle -> busy 0, pointer 0, all writable registers 0 immediately.
